// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - status word bit offsets and irq enable indices for the UART status block
package uart_pkg;

  // Offsets above the data field in the status word
  localparam int ST_VALID  = 0;
  localparam int ST_RXBUSY = 1;
  localparam int ST_TXBUSY = 2;
  localparam int ST_FRAME  = 3;
  localparam int ST_OVR    = 4;
  localparam int ST_PAR    = 5;
  localparam int ST_THR    = 6;
  localparam int ST_IRQ    = 7;
  localparam int ST_FLAGS  = 8;

  localparam int IE_FRAME = 0;
  localparam int IE_PAR   = 1;
  localparam int IE_OVR   = 2;
  localparam int IE_THR   = 3;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - first-word fall-through synchronous FIFO with occupancy counter
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [WIDTH-1:0]         head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop on a full FIFO frees the slot the simultaneous push lands in
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_status_fifo_reg.sv
// rtl/uart_status_fifo_reg.sv - UART status register with RX FIFO, sticky errors and maskable irq
module uart_status_fifo_reg
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int THRESH = 4
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    recv_error,
  input  logic                    recv_parity_err,
  input  logic                    recv_busy,
  input  logic                    tnsm_busy,
  input  logic                    recv_int,
  input  logic [DATA_W-1:0]       recv_data,
  input  logic                    re,
  input  logic [DATA_W+7:0]       rmask,
  input  logic [3:0]              irq_en,
  output logic [DATA_W+7:0]       status_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    irq
);

  localparam int STATUS_W = DATA_W + ST_FLAGS;
  localparam int LVL_W    = $clog2(DEPTH) + 1;

  logic              full;
  logic              empty;
  logic              pop_req;
  logic [DATA_W-1:0] head;
  logic              rx_busy;
  logic              tx_busy;
  logic              frame_err;
  logic              overrun;
  logic              parity_err;
  logic              thresh;
  logic              overrun_set;
  logic              unused_rmask;

  assign pop_req = re & rmask[DATA_W+ST_VALID];

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .arst_n (arst_n),
    .push   (recv_int),
    .pop    (pop_req),
    .wdata  (recv_data),
    .full   (full),
    .empty  (empty),
    .level  (level),
    .head   (head)
  );

  // full implies non-empty, so any pop request relieves the overrun
  assign overrun_set = recv_int & full & ~pop_req;

  // Set beats a same-cycle clear on every sticky bit
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_busy    <= 1'b0;
      tx_busy    <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_busy    <= recv_busy;
      tx_busy    <= tnsm_busy;
      frame_err  <= recv_error | (frame_err & ~(re & rmask[DATA_W+ST_FRAME]));
      overrun    <= overrun_set | (overrun & ~(re & rmask[DATA_W+ST_OVR]));
      parity_err <= recv_parity_err | (parity_err & ~(re & rmask[DATA_W+ST_PAR]));
    end
  end

  assign thresh = (level >= LVL_W'(THRESH));
  assign irq    = |(irq_en & {thresh, overrun, parity_err, frame_err});

  always_comb begin
    status_data                     = '0;
    status_data[DATA_W-1:0]         = head;
    status_data[DATA_W+ST_VALID]    = ~empty;
    status_data[DATA_W+ST_RXBUSY]   = rx_busy;
    status_data[DATA_W+ST_TXBUSY]   = tx_busy;
    status_data[DATA_W+ST_FRAME]    = frame_err;
    status_data[DATA_W+ST_OVR]      = overrun;
    status_data[DATA_W+ST_PAR]      = parity_err;
    status_data[DATA_W+ST_THR]      = thresh;
    status_data[STATUS_W-1]         = irq;
  end

  assign unused_rmask = ^{rmask[DATA_W-1:0], rmask[DATA_W+ST_RXBUSY], rmask[DATA_W+ST_TXBUSY],
                          rmask[DATA_W+ST_THR], rmask[DATA_W+ST_IRQ]};

endmodule
